// File: rtl/serial_arith_pkg.sv
// Shared state encodings for the bit-serial arithmetic blocks.
// Reused by the serial adder and serial subtractor.
package serial_arith_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/one_bit_subtractor.sv
// Gate-level full-subtractor cell: D = A-B-Bin, Bout = borrow out.
// Built from primitive gates only.
module one_bit_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  logic ab_x;
  logic a_n;
  logic p_ab;
  logic p_ai;
  logic p_bi;

  xor u_x0 (ab_x, A, B);
  xor u_x1 (D, ab_x, Bin);
  not u_n0 (a_n, A);
  and u_a0 (p_ab, a_n, B);
  and u_a1 (p_ai, a_n, Bin);
  and u_a2 (p_bi, B, Bin);
  or  u_o0 (Bout, p_ab, p_ai, p_bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: Result = A - B - Bin over WIDTH clocks, LSB first.
// One shared full-subtractor cell plus a registered borrow chain.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Bout,
  output logic             Ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;

  logic             cell_d;
  logic             cell_bo;

  one_bit_subtractor u_cell (
    .A    (a_q[0]),
    .B    (b_q[0]),
    .Bin  (brw_q),
    .D    (cell_d),
    .Bout (cell_bo)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (Start) begin
          state_d = ST_SHIFT;
          a_d     = A;
          b_d     = B;
          brw_d   = Bin;
          cnt_d   = '0;
          amsb_d  = A[WIDTH-1];
          bmsb_d  = B[WIDTH-1];
        end
      end
      ST_SHIFT: begin
        res_d = {cell_d, res_q[WIDTH-1:1]};
        brw_d = cell_bo;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        // Exit compare wins over the increment, so cnt never wraps.
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          bout_d  = cell_bo;
          ovf_d   = (amsb_q ^ bmsb_q) & (cell_d ^ amsb_q);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
    end
  end

  assign Busy   = (state_q == ST_SHIFT);
  assign Done   = (state_q == ST_DONE);
  assign Result = res_q;
  assign Bout   = bout_q;
  assign Ovf    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
// Expected values are hand-computed constants.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] res;
  logic         bout;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .Clk    (clk),
    .Reset  (rst),
    .Start  (start),
    .A      (a),
    .B      (b),
    .Bin    (bin),
    .Busy   (busy),
    .Done   (done),
    .Result (res),
    .Bout   (bout),
    .Ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a request before edge e0; returns #1 after e0.
  task automatic start_op(input logic [W-1:0] av,
                          input logic [W-1:0] bv,
                          input logic bi);
    @(negedge clk);
    a = av; b = bv; bin = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // From #1 after e0, wait for Done; returns #1 after the Done edge.
  task automatic wait_done(input string tag);
    int cyc;
    int bcnt;
    cyc = 0;
    bcnt = 0;
    while (!done && cyc < 20) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_latency"}, cyc, W);
    chk({tag, "_busycnt"}, bcnt, W);
    chk({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_out(input string tag,
                           input logic [W-1:0] er,
                           input logic eb,
                           input logic eo);
    chk({tag, "_result"}, {24'd0, res}, {24'd0, er});
    chk({tag, "_bout"}, {31'd0, bout}, {31'd0, eb});
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
  endtask

  initial begin
    int dpulses;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;

    // 1. reset
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    check_out("rst", 8'h00, 1'b0, 1'b0);

    // 2. 5A - 3C
    start_op(8'h5A, 8'h3C, 1'b0);
    chk("t2_busy_e0", {31'd0, busy}, 32'd1);
    wait_done("t2");
    check_out("t2", 8'h1E, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("t2_done_pulse", {31'd0, done}, 32'd0);
    check_out("t2_hold", 8'h1E, 1'b0, 1'b0);

    // 3. borrow and signed overflow
    start_op(8'h00, 8'h01, 1'b0);
    wait_done("t3a");
    check_out("t3a", 8'hFF, 1'b1, 1'b0);
    start_op(8'h80, 8'h01, 1'b0);
    wait_done("t3b");
    check_out("t3b", 8'h7F, 1'b0, 1'b1);

    // 4. Bin=1, then back-to-back start from Done
    start_op(8'h10, 8'h0F, 1'b1);
    wait_done("t4a");
    check_out("t4a", 8'h00, 1'b0, 1'b0);
    start_op(8'h03, 8'h05, 1'b0);
    chk("t4_b2b_busy", {31'd0, busy}, 32'd1);
    chk("t4_b2b_done", {31'd0, done}, 32'd0);
    wait_done("t4b");
    check_out("t4b", 8'hFE, 1'b1, 1'b0);

    // 5. start during SHIFT is ignored
    start_op(8'h20, 8'h01, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t5_busy_mid", {31'd0, busy}, 32'd1);
    dpulses = 0;
    for (int i = 0; i < 16; i++) begin
      if (done) begin
        dpulses++;
        chk("t5_result", {24'd0, res}, 32'h1F);
      end
      @(posedge clk); #1;
    end
    chk("t5_pulses", dpulses, 1);
    chk("t5_idle_busy", {31'd0, busy}, 32'd0);

    // 6. reset mid-operation aborts
    start_op(8'h77, 8'h11, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_done", {31'd0, done}, 32'd0);
    check_out("t6", 8'h00, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b0;
    dpulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) dpulses++;
    end
    chk("t6_no_done", dpulses, 0);
    start_op(8'h77, 8'h11, 1'b0);
    wait_done("t6b");
    check_out("t6b", 8'h66, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
